// File: rtl/io_rx_tx_server_if.sv
// Client-facing getc/putc bus of io_rx_tx_server.
// The server modport is the view seen from inside the block.
interface if_io;
   logic       getc_pop;
   logic       putc_push;
   logic [7:0] putc_char;
   logic       inbuf_full;
   logic       getc_en;
   logic [7:0] getc_char;
   logic       putc_push_done;

   modport server (
      input  getc_pop,
      input  putc_push,
      input  putc_char,
      output inbuf_full,
      output getc_en,
      output getc_char,
      output putc_push_done
   );
endinterface

// File: rtl/io_rx_tx_server.sv
// UART byte server: receive FIFO with first-word fall-through getc, four-phase putc to the transmitter.
// Optional macro IO_RX_OVERRUN_EN adds a sticky rx_overrun flag for bytes dropped on a full FIFO.
module io_rx_tx_server #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_char,
   input  logic       tx_ready,
   output logic       tx_start,
   output logic [7:0] tx_char,
`ifdef IO_RX_OVERRUN_EN
   output logic       rx_overrun,
`endif
   if_io.server       io
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          do_pop;
   logic          do_push;
   tx_state_t     state;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign do_pop  = io.getc_pop && !empty;
   // A pop on a full FIFO frees the head slot, so the incoming byte may still be written.
   assign do_push = rx_valid && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= rx_char;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef IO_RX_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_overrun <= 1'b0;
      end else if (rx_valid && !do_push) begin
         rx_overrun <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx_char <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (io.putc_push) begin
                  tx_char <= io.putc_char;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (!io.putc_push) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are masked by rst_n so a reset cycle never leaks a strobe or stale status.
   assign tx_start          = rst_n && (state == SEND) && tx_ready;
   assign io.putc_push_done = rst_n && (state == DONE);
   assign io.getc_en        = rst_n && !empty;
   assign io.inbuf_full     = rst_n && full;
   assign io.getc_char      = (rst_n && !empty) ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_io_rx_tx_server.sv
// Scoreboard bench for io_rx_tx_server: queue-based receive model and expected transmit byte queue.
// Define IO_RX_OVERRUN_EN for both RTL and bench to cover the overrun flag.
module tb_io_rx_tx_server;
   localparam int DEPTH = 16;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_char  = 8'h00;
   logic       tx_ready = 1'b0;
   logic       tx_start;
   logic [7:0] tx_char;
`ifdef IO_RX_OVERRUN_EN
   logic       rx_overrun;
`endif

   int checks = 0;
   int fails  = 0;

   byte unsigned rx_model[$];
   byte unsigned tx_exp[$];
   bit           overrun_model = 1'b0;
   bit           model_pop;

   if_io io();

   io_rx_tx_server #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_valid (rx_valid),
      .rx_char  (rx_char),
      .tx_ready (tx_ready),
      .tx_start (tx_start),
      .tx_char  (tx_char),
`ifdef IO_RX_OVERRUN_EN
      .rx_overrun (rx_overrun),
`endif
      .io       (io)
   );

   always #5 clk = ~clk;

   task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a byte queue bounded at DEPTH, updated with the inputs seen at each edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         rx_model.delete();
         overrun_model = 1'b0;
      end else begin
         model_pop = io.getc_pop && (rx_model.size() != 0);
         if (rx_valid) begin
            if (rx_model.size() < DEPTH || model_pop) rx_model.push_back(rx_char);
            else overrun_model = 1'b1;
         end
         if (model_pop) void'(rx_model.pop_front());
      end
   end

   // Monitor: compares receive-side status every cycle and each transmit strobe against the queue.
   always @(negedge clk) begin
      check_output("getc_en", {31'd0, io.getc_en}, {31'd0, rx_model.size() != 0});
      check_output("inbuf_full", {31'd0, io.inbuf_full}, {31'd0, rx_model.size() == DEPTH});
      check_output("getc_char", {24'd0, io.getc_char},
                   (rx_model.size() != 0) ? {24'd0, rx_model[0]} : 32'd0);
`ifdef IO_RX_OVERRUN_EN
      check_output("rx_overrun", {31'd0, rx_overrun}, {31'd0, overrun_model});
`endif
      if (tx_start === 1'b1) begin
         if (tx_exp.size() == 0) begin
            check_output("unexpected_tx_start", {31'd0, tx_start}, 32'd0);
         end else begin
            check_output("tx_char", {24'd0, tx_char}, {24'd0, tx_exp.pop_front()});
         end
      end
   end

   task automatic do_reset();
      rst_n        = 1'b0;
      io.putc_push = 1'b0;
      io.getc_pop  = 1'b0;
      rx_valid     = 1'b1;
      rx_char      = 8'hAA;
      tx_exp.delete();
      repeat (3) tick();
      rx_valid = 1'b0;
      rst_n    = 1'b1;
   endtask

   task automatic apply_stimulus(bit v, logic [7:0] c, bit pop);
      rx_valid    = v;
      rx_char     = c;
      io.getc_pop = pop;
      tick();
      rx_valid    = 1'b0;
      io.getc_pop = 1'b0;
   endtask

   task automatic putc(logic [7:0] c, int ready_delay, int hold);
      int n;
      tx_ready      = (ready_delay == 0);
      io.putc_char  = c;
      io.putc_push  = 1'b1;
      tx_exp.push_back(c);
      tick();
      io.putc_char  = ~c;
      n = 0;
      while (!io.putc_push_done && n < 40) begin
         if (n == ready_delay) tx_ready = 1'b1;
         else check_output("no_early_tx_start", {31'd0, tx_start}, 32'd0);
         tick();
         n++;
      end
      check_output("putc_latency", n, ready_delay + 1);
      repeat (hold) begin
         tick();
         check_output("done_held", {31'd0, io.putc_push_done}, 32'd1);
      end
      io.putc_push = 1'b0;
      tick();
      check_output("done_dropped", {31'd0, io.putc_push_done}, 32'd0);
   endtask

   initial begin
      io.getc_pop   = 1'b0;
      io.putc_push  = 1'b0;
      io.putc_char  = 8'h00;

      do_reset();
      check_output("rst_getc_en", {31'd0, io.getc_en}, 32'd0);
      check_output("rst_inbuf_full", {31'd0, io.inbuf_full}, 32'd0);
      check_output("rst_getc_char", {24'd0, io.getc_char}, 32'd0);
      check_output("rst_done", {31'd0, io.putc_push_done}, 32'd0);
      check_output("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check_output("rst_tx_char", {24'd0, tx_char}, 32'd0);

      apply_stimulus(1'b1, 8'h41, 1'b0);
      check_output("first_byte", {24'd0, io.getc_char}, 32'h41);
      check_output("first_en", {31'd0, io.getc_en}, 32'd1);
      apply_stimulus(1'b1, 8'h42, 1'b0);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      check_output("second_byte", {24'd0, io.getc_char}, 32'h42);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      check_output("drained_en", {31'd0, io.getc_en}, 32'd0);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      check_output("pop_empty_en", {31'd0, io.getc_en}, 32'd0);

      do_reset();
      for (int i = 0; i <= DEPTH; i++) begin
         apply_stimulus(1'b1, 8'(i), 1'b0);
         if (i == DEPTH - 1) check_output("full_after_16", {31'd0, io.inbuf_full}, 32'd1);
      end
      check_output("full_head", {24'd0, io.getc_char}, 32'h00);
`ifdef IO_RX_OVERRUN_EN
      check_output("overrun_set", {31'd0, rx_overrun}, 32'd1);
`endif
      apply_stimulus(1'b1, 8'h55, 1'b1);
      check_output("full_push_pop", {31'd0, io.inbuf_full}, 32'd1);
      for (int i = 1; i < DEPTH; i++) begin
         check_output("drain_order", {24'd0, io.getc_char}, i);
         apply_stimulus(1'b0, 8'h00, 1'b1);
      end
      check_output("last_is_55", {24'd0, io.getc_char}, 32'h55);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      check_output("empty_again", {31'd0, io.getc_en}, 32'd0);

      putc(8'h7A, 5, 0);
      putc(8'hC3, 0, 0);
      putc(8'h3C, 0, 10);

      // Abandon a byte in SEND: reset arrives in the same cycle tx_ready rises.
      tx_ready     = 1'b0;
      io.putc_char = 8'h99;
      io.putc_push = 1'b1;
      tick();
      rst_n        = 1'b0;
      tx_ready     = 1'b1;
      io.putc_push = 1'b0;
      tick();
      check_output("rst_send_tx_char", {24'd0, tx_char}, 32'd0);
      check_output("rst_send_done", {31'd0, io.putc_push_done}, 32'd0);
      rst_n = 1'b1;
      tick();
      check_output("idle_after_rst", {31'd0, tx_start}, 32'd0);
      tick();

      fork
         begin
            for (int i = 0; i < 400; i++) begin
               apply_stimulus($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 40);
            end
         end
         begin
            for (int k = 0; k < 12; k++) begin
               putc(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 3));
               repeat ($urandom_range(0, 3)) tick();
            end
         end
      join
      repeat (DEPTH + 2) apply_stimulus(1'b0, 8'h00, 1'b1);
      check_output("final_empty", {31'd0, io.getc_en}, 32'd0);
      check_output("tx_all_sent", tx_exp.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/io_rx_tx_server.md
IO_RX_TX_SERVER -- requirements
Module: io_rx_tx_server

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning receive FIFO depth in bytes (power of two, 2..256).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port rx_valid  input  1  one-cycle strobe from the UART receiver: byte available.
REQ-005 The block SHALL have port rx_char  input  8  received byte, valid with rx_valid.
REQ-006 The block SHALL have port tx_ready  input  1  UART transmitter idle and able to accept a byte.
REQ-007 The block SHALL have port tx_start  output  1  one-cycle strobe handing tx_char to the transmitter.
REQ-008 The block SHALL have port tx_char  output  8  byte to transmit.
REQ-009 The block SHALL have port io  if_io.server  --  client-facing bus: inputs getc_pop, putc_push, putc_char[7:0]; outputs inbuf_full, getc_en, getc_char[7:0], putc_push_done.

Function
REQ-010 The receive path SHALL be a DEPTH-entry circular FIFO with read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH and an occupancy count of log2(DEPTH)+1 bits.
REQ-011 rx_valid with FIFO not full SHALL write rx_char at the write pointer; the byte SHALL be visible on getc_char on the next cycle.
REQ-012 getc_en SHALL equal (count != 0); getc_char SHALL present the head entry (first-word fall-through), 0x00 when empty.
REQ-013 getc_pop while getc_en=1 SHALL remove the head at that edge; getc_pop while empty SHALL be ignored.
REQ-014 inbuf_full SHALL equal (count == DEPTH); rx_valid while full and without a simultaneous pop SHALL drop the byte, FIFO unchanged.
REQ-015 Simultaneous rx_valid and valid getc_pop SHALL both take effect, count unchanged, including when full.
REQ-016 The transmit path SHALL be an FSM with states IDLE, SEND, DONE.
REQ-017 IDLE: putc_push=1 SHALL latch putc_char into tx_char and go to SEND.
REQ-018 SEND: tx_start SHALL equal tx_ready; when tx_ready=1 the FSM SHALL go to DONE, otherwise stay in SEND.
REQ-019 DONE: putc_push_done SHALL be 1; the FSM SHALL return to IDLE only when putc_push=0 (four-phase handshake); putc_push held high in DONE SHALL not start a second byte.
REQ-020 Minimum putc latency: push sampled in cycle n, tx_start in n+1 (if tx_ready), putc_push_done from n+2.
REQ-021 putc_char changes while in SEND or DONE SHALL not affect tx_char.
REQ-022 Receive and transmit paths SHALL operate independently and concurrently.

Reset
REQ-023 rst_n=0 at a clock edge SHALL empty the FIFO (pointers, count = 0), set FSM to IDLE, and clear tx_char to 0x00.
REQ-024 During and after reset: getc_en=0, inbuf_full=0, getc_char=0x00, putc_push_done=0, tx_start=0.
REQ-025 Reset mid-transfer SHALL abandon the pending byte without asserting tx_start; rx_valid during reset SHALL be ignored.

Configuration
REQ-026 With IO_RX_OVERRUN_EN defined, the block SHALL add output rx_overrun (1 bit), set on any byte dropped per REQ-014, cleared only by reset.
REQ-027 Without IO_RX_OVERRUN_EN, port rx_overrun and its logic SHALL be absent; drop behaviour is otherwise identical.

Verification
REQ-028 Reset, then rx_valid with 0x41, 0x42 -> getc_en=1 next cycle, getc_char=0x41; pop -> 0x42; pop -> getc_en=0.
REQ-029 DEPTH=16: write 17 bytes 0x00..0x10 without pop -> inbuf_full=1 after 16th; 0x10 dropped; rx_overrun=1 if IO_RX_OVERRUN_EN; reading returns 0x00..0x0F.
REQ-030 Full FIFO, rx_valid 0x55 plus getc_pop same cycle -> count stays 16, head advances, 0x55 stored last.
REQ-031 tx_ready=0, putc_push with 0x7A -> no tx_start; raise tx_ready after 5 cycles -> one tx_start with tx_char=0x7A, then putc_push_done=1 until putc_push drops.
REQ-032 putc_push held high 10 cycles after putc_push_done -> exactly one tx_start; rst_n=0 while in SEND -> tx_start never asserted, FSM IDLE.
